// File: rtl/rxecrc_check.sv
// ============================================================================
// Module   : rxecrc_check
// Purpose  : Receive-side CRC-32 checker for a nibble stream (low nibble
//            first). Runs the reflected CRC-32 over every nibble of a frame,
//            FCS included, and compares the residue at end of frame.
//            Optionally strips the 8 trailing FCS nibbles by delaying the
//            data through an 8-deep nibble shift register.
// Ports    : i_clk       system clock (posedge)
//            i_areset_n  asynchronous active-low reset
//            i_ce        nibble-rate enable
//            i_en        1: check (and strip), 0: transparent pass
//            i_cancel    abort current frame
//            i_v / i_d   input nibble valid / data
//            o_v / o_d   output nibble valid / data
//            o_err       CRC or runt error of last completed frame
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rxecrc_check #(
   parameter bit          OPT_STRIP   = 1'b1,
   parameter logic [31:0] CRC_POLY    = 32'hedb88320,
   parameter logic [31:0] CRC_RESIDUE = 32'hdebb20e3
) (
   input  logic       i_clk,
   input  logic       i_areset_n,
   input  logic       i_ce,
   input  logic       i_en,
   input  logic       i_cancel,
   input  logic       i_v,
   input  logic [3:0] i_d,
   output logic       o_v,
   output logic [3:0] o_d,
   output logic       o_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [31:0] crc;
   logic [3:0]  fill_cnt;
   logic [3:0]  dline [0:7];
   logic        frame_en;

   // A nibble counts only when it is not discarded by a same-cycle cancel.
   logic nib_in, frame_start, frame_end, en_cur, strip_mode;

   assign nib_in      = i_v && !i_cancel;
   assign frame_start = (state == IDLE) && nib_in;
   assign frame_end   = (state != IDLE) && !i_v && !i_cancel;
   // i_en is only looked at on the first nibble; it is latched for the frame.
   assign en_cur      = frame_start ? i_en : frame_en;
   assign strip_mode  = OPT_STRIP && en_cur;

   // Nibble-at-a-time reflected update. With the low 5 bits of the polynomial
   // zero, each set bit b of x contributes the polynomial shifted 3-b places
   // with no further feedback, so the bit terms can simply be XORed together.
   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
      logic [3:0]  x;
      logic [31:0] r;
      x = c[3:0] ^ d;
      r = {4'h0, c[31:4]};
      for (int b = 0; b < 4; b++) begin
         if (x[b]) r = r ^ (CRC_POLY >> (3 - b));
      end
      return r;
   endfunction

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state <= IDLE;
      end else if (i_ce) begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (nib_in) state_next = FILL;
         FILL: begin
            if (i_cancel || !i_v)       state_next = IDLE;
            else if (fill_cnt == 4'd7)  state_next = RUN;
         end
         RUN:  if (i_cancel || !i_v)    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         crc      <= 32'hffffffff;
         fill_cnt <= 4'd0;
         frame_en <= 1'b0;
         o_v      <= 1'b0;
         o_d      <= 4'h0;
         o_err    <= 1'b0;
         for (int i = 0; i < 8; i++) dline[i] <= 4'h0;
      end else if (i_ce) begin
         if (i_cancel) begin
            crc      <= 32'hffffffff;
            fill_cnt <= 4'd0;
            o_v      <= 1'b0;
            o_err    <= 1'b0;
         end else if (i_v) begin
            crc      <= crc_nib(crc, i_d);
            fill_cnt <= (fill_cnt == 4'd8) ? 4'd8 : fill_cnt + 4'd1;
            dline[0] <= i_d;
            for (int i = 1; i < 8; i++) dline[i] <= dline[i-1];
            if (frame_start) begin
               frame_en <= i_en;
               o_err    <= 1'b0;
            end
            if (strip_mode) begin
               // Once 8 nibbles are held, each new arrival pushes out the
               // oldest; the final 8 (the FCS) stay behind and are dropped.
               o_v <= (fill_cnt == 4'd8);
               if (fill_cnt == 4'd8) o_d <= dline[7];
            end else begin
               o_v <= 1'b1;
               o_d <= i_d;
            end
         end else begin
            o_v <= 1'b0;
            if (frame_end) begin
               if (frame_en) o_err <= (crc != CRC_RESIDUE) || (fill_cnt < 4'd8);
               crc      <= 32'hffffffff;
               fill_cnt <= 4'd0;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rxecrc_check.sv
// ============================================================================
// Module   : tb_rxecrc_check
// Purpose  : Self-checking bench for rxecrc_check. Expected outputs come from
//            a bit-serial CRC-32 model and a frame-level view of stripping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rxecrc_check;

   localparam logic [31:0] POLY = 32'hedb88320;
   localparam logic [31:0] RES  = 32'hdebb20e3;

   typedef logic [3:0] nq_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ce = 1'b0;
   logic       en = 1'b1;
   logic       cancel = 1'b0;
   logic       v = 1'b0;
   logic [3:0] d = 4'h0;
   logic       o_v;
   logic [3:0] o_d;
   logic       o_err;

   int errors = 0;
   int checks = 0;
   bit ce_div = 1'b0;
   int cyc = 0;
   int ce_idx = 0;
   int first_ov = -1;
   nq_t got;
   nq_t f1;

   rxecrc_check dut (
      .i_clk      (clk),
      .i_areset_n (rst_n),
      .i_ce       (ce),
      .i_en       (en),
      .i_cancel   (cancel),
      .i_v        (v),
      .i_d        (d),
      .o_v        (o_v),
      .o_d        (o_d),
      .o_err      (o_err)
   );

   always #5 clk = ~clk;

   // Bit-serial reflected CRC over nibbles, LSB of each nibble first.
   function automatic logic [31:0] crc_bits(input nq_t q);
      logic [31:0] c;
      logic        fb;
      c = 32'hffffffff;
      foreach (q[i]) begin
         for (int b = 0; b < 4; b++) begin
            fb = c[0] ^ q[i][b];
            c  = c >> 1;
            if (fb) c = c ^ POLY;
         end
      end
      return c;
   endfunction

   function automatic nq_t model_out(input nq_t f, input logic en_i);
      nq_t r;
      if (!en_i) return f;
      for (int i = 0; i + 8 < f.size(); i++) r.push_back(f[i]);
      return r;
   endfunction

   function automatic logic model_err(input nq_t f, input logic en_i);
      if (!en_i) return 1'b0;
      return (f.size() < 8) || (crc_bits(f) != RES);
   endfunction

   function automatic string q2s(input nq_t q);
      string s;
      s = "";
      foreach (q[i]) s = {s, $sformatf("%h", q[i])};
      return s;
   endfunction

   // One i_ce-qualified nibble slot; outputs are sampled 1 time unit after
   // each enabled edge and o_v nibbles are collected.
   task automatic step(input logic vi, input logic [3:0] di, input logic ci);
      bit done;
      done = 1'b0;
      v = vi; d = di; cancel = ci;
      while (!done) begin
         ce = ce_div ? ((cyc % 4) == 3) : 1'b1;
         @(posedge clk);
         #1;
         cyc++;
         if (ce) begin
            done = 1'b1;
            if (o_v) begin
               got.push_back(o_d);
               if (first_ov < 0) first_ov = ce_idx;
            end
            ce_idx++;
         end
      end
   endtask

   task automatic begin_frame(input logic en_i);
      got.delete();
      first_ov = -1;
      ce_idx = 0;
      en = en_i;
   endtask

   task automatic run_frame(input nq_t f, input logic en_i);
      begin_frame(en_i);
      foreach (f[i]) step(1'b1, f[i], 1'b0);
      step(1'b0, 4'h0, 1'b0);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_v !== 1'b0)  begin errors++; $display("FAIL reset_o_v got=%b exp=0", o_v); end
      checks++; if (o_d !== 4'h0)  begin errors++; $display("FAIL reset_o_d got=%h exp=0", o_d); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_o_err got=%b exp=0", o_err); end
      rst_n = 1'b1;
      step(1'b0, 4'h0, 1'b0);
   endtask

   task automatic test_good();
      string exp_s;
      exp_s = q2s(model_out(f1, 1'b1));
      run_frame(f1, 1'b1);
      checks++; if (got.size() != 18) begin errors++; $display("FAIL good_count got=%0d exp=18", got.size()); end
      checks++; if (q2s(got) != exp_s) begin errors++; $display("FAIL good_data got=%s exp=%s", q2s(got), exp_s); end
      // First o_v sample follows the edge of nibble 8, i.e. visible in the 9th i_ce cycle.
      checks++; if (first_ov != 8) begin errors++; $display("FAIL good_latency got=%0d exp=8", first_ov); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL good_err got=%b exp=0", o_err); end
   endtask

   task automatic test_bad();
      nq_t   f2;
      string exp_s;
      f2 = f1;
      f2[5] = 4'h2;
      exp_s = q2s(model_out(f2, 1'b1));
      run_frame(f2, 1'b1);
      checks++; if (q2s(got) != exp_s) begin errors++; $display("FAIL bad_data got=%s exp=%s", q2s(got), exp_s); end
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL bad_err got=%b exp=1", o_err); end
      begin_frame(1'b1);
      step(1'b1, f1[0], 1'b0);
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL bad_err_clear got=%b exp=0", o_err); end
      for (int i = 1; i < f1.size(); i++) step(1'b1, f1[i], 1'b0);
      step(1'b0, 4'h0, 1'b0);
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL bad_next_good got=%b exp=0", o_err); end
   endtask

   task automatic test_runt();
      nq_t r;
      for (int i = 0; i < 5; i++) r.push_back(4'($urandom));
      run_frame(r, 1'b1);
      checks++; if (got.size() != 0) begin errors++; $display("FAIL runt_count got=%0d exp=0", got.size()); end
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL runt_err got=%b exp=1", o_err); end
   endtask

   task automatic test_cancel();
      begin_frame(1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, f1[i], 1'b0);
      checks++; if (o_v !== 1'b1) begin errors++; $display("FAIL cancel_pre_v got=%b exp=1", o_v); end
      step(1'b1, f1[12], 1'b1);
      checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL cancel_v got=%b exp=0", o_v); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL cancel_err got=%b exp=0", o_err); end
      step(1'b0, 4'h0, 1'b0);
      run_frame(f1, 1'b1);
      checks++; if (q2s(got) != q2s(model_out(f1, 1'b1))) begin errors++; $display("FAIL cancel_next_data got=%s exp=%s", q2s(got), q2s(model_out(f1, 1'b1))); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL cancel_next_err got=%b exp=0", o_err); end
   endtask

   task automatic test_async_reset();
      begin_frame(1'b1);
      for (int i = 0; i < 11; i++) step(1'b1, f1[i], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL areset_o_v got=%b exp=0", o_v); end
      checks++; if (o_d !== 4'h0) begin errors++; $display("FAIL areset_o_d got=%h exp=0", o_d); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL areset_o_err got=%b exp=0", o_err); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1'b0, 4'h0, 1'b0);
      run_frame(f1, 1'b1);
      checks++; if (q2s(got) != q2s(model_out(f1, 1'b1))) begin errors++; $display("FAIL areset_next_data got=%s exp=%s", q2s(got), q2s(model_out(f1, 1'b1))); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL areset_next_err got=%b exp=0", o_err); end
   endtask

   task automatic test_ce_div();
      ce_div = 1'b1;
      run_frame(f1, 1'b1);
      checks++; if (q2s(got) != q2s(model_out(f1, 1'b1))) begin errors++; $display("FAIL cediv_data got=%s exp=%s", q2s(got), q2s(model_out(f1, 1'b1))); end
      checks++; if (first_ov != 8) begin errors++; $display("FAIL cediv_latency got=%0d exp=8", first_ov); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL cediv_err got=%b exp=0", o_err); end
      run_frame(f1, 1'b0);
      checks++; if (got.size() != 26) begin errors++; $display("FAIL pass_count got=%0d exp=26", got.size()); end
      checks++; if (q2s(got) != q2s(f1)) begin errors++; $display("FAIL pass_data got=%s exp=%s", q2s(got), q2s(f1)); end
      checks++; if (first_ov != 0) begin errors++; $display("FAIL pass_latency got=%0d exp=0", first_ov); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL pass_err got=%b exp=0", o_err); end
      ce_div = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         nq_t         f;
         nq_t         data;
         logic [31:0] c;
         logic        en_i;
         int          len;
         string       exp_s;
         logic        exp_e;
         len = $urandom_range(0, 20);
         for (int i = 0; i < len; i++) data.push_back(4'($urandom));
         c = ~crc_bits(data);
         f = data;
         for (int i = 0; i < 8; i++) f.push_back(c[4*i +: 4]);
         if ($urandom_range(0, 3) == 0) begin
            int keep;
            keep = $urandom_range(1, 7);
            while (f.size() > keep) void'(f.pop_back());
         end
         if ($urandom_range(0, 9) < 3) begin
            int p;
            p = $urandom_range(0, f.size() - 1);
            f[p] = f[p] ^ 4'($urandom_range(1, 15));
         end
         en_i  = ($urandom_range(0, 3) != 0);
         exp_s = q2s(model_out(f, en_i));
         exp_e = model_err(f, en_i);
         run_frame(f, en_i);
         checks++; if (q2s(got) != exp_s) begin errors++; $display("FAIL rand%0d_data got=%s exp=%s", n, q2s(got), exp_s); end
         checks++; if (o_err !== exp_e) begin errors++; $display("FAIL rand%0d_err got=%b exp=%b", n, o_err, exp_e); end
      end
   endtask

   initial begin
      string s;
      logic [3:0] fcs [0:7];
      fcs = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
      s = "123456789";
      for (int i = 0; i < s.len(); i++) begin
         logic [7:0] ch;
         ch = s[i];
         f1.push_back(ch[3:0]);
         f1.push_back(ch[7:4]);
      end
      for (int i = 0; i < 8; i++) f1.push_back(fcs[i]);

      test_reset();
      test_good();
      test_bad();
      test_runt();
      test_cancel();
      test_async_reset();
      test_ce_div();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
